// File: rtl/fbank_pkg.sv
// fbank_pkg: shared constants for the mel filterbank accumulator.
//   MEL_EDGE   : filter edge bins, strictly increasing, last edge <= N_BINS
//   WEIGHT_ONE : unity triangle weight in Q1.16
//   *_W        : operand / product / contribution widths
//   state_t    : accumulator control states
//   edge_at()  : bounds-safe edge lookup (out-of-range reads never match a bin)
package fbank_pkg;

    localparam int MEL_N = 42;

    localparam logic [10:0] MEL_EDGE [MEL_N] = '{
        11'd2,   11'd6,   11'd10,  11'd14,  11'd18,  11'd22,  11'd26,
        11'd30,  11'd35,  11'd40,  11'd45,  11'd51,  11'd57,  11'd63,
        11'd70,  11'd77,  11'd85,  11'd93,  11'd102, 11'd111, 11'd121,
        11'd131, 11'd142, 11'd154, 11'd166, 11'd179, 11'd193, 11'd208,
        11'd224, 11'd241, 11'd259, 11'd278, 11'd298, 11'd319, 11'd341,
        11'd364, 11'd388, 11'd413, 11'd439, 11'd466, 11'd480, 11'd500
    };

    localparam logic [16:0] WEIGHT_ONE = 17'h10000;

    localparam int PWR_W     = 32;
    localparam int WGT_W     = 17;
    localparam int FRAC_W    = 16;
    localparam int PROD_W    = PWR_W + WGT_W;    // 49
    localparam int CONTRIB_W = PROD_W - FRAC_W;  // 33

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    function automatic logic [10:0] edge_at(input int idx);
        if (idx < 0 || idx >= MEL_N) return '1;
        return MEL_EDGE[idx];
    endfunction

endpackage

// File: rtl/fbank_mac.sv
// fbank_mac: registered dual product for one power bin.
//   clk    : clock
//   en     : load enable (a bin is in this stage)
//   pwr    : unsigned bin power
//   weight : Q1.16 rising-side weight w
//   rise   : (pwr * w) >> 16, registered
//   fall   : (pwr * (1 - w)) >> 16, registered
module fbank_mac
    import fbank_pkg::*;
(
    input  logic                 clk,
    input  logic                 en,
    input  logic [PWR_W-1:0]     pwr,
    input  logic [WGT_W-1:0]     weight,
    output logic [CONTRIB_W-1:0] rise,
    output logic [CONTRIB_W-1:0] fall
);

    logic [WGT_W-1:0]  weight_inv;
    logic [PROD_W-1:0] prod_rise;
    logic [PROD_W-1:0] prod_fall;

    assign weight_inv = WEIGHT_ONE - weight;
    assign prod_rise  = PROD_W'(pwr) * PROD_W'(weight);
    assign prod_fall  = PROD_W'(pwr) * PROD_W'(weight_inv);

    always_ff @(posedge clk) begin
        if (en) begin
            rise <= CONTRIB_W'(prod_rise >> FRAC_W);
            fall <= CONTRIB_W'(prod_fall >> FRAC_W);
        end
    end

endmodule

// File: rtl/fbank_accum.sv
// fbank_accum: mel filterbank accumulator.
//   clk, rst            : clock, synchronous active-high reset
//   pwr_valid/ready     : power bin handshake; pwr_data bin power, pwr_last ends frame
//   lut_addr            : weight RAM address (= bin counter); lut_rd_data returns next cycle
//   lut_wr_en/wr_data   : unused write side, tied low
//   fb_valid/idx/data   : one saturated energy per filter, in index order
//   frame_done          : pulses with the last filter of the frame
module fbank_accum
    import fbank_pkg::*;
#(
    parameter int N_BINS = 512,
    parameter int N_FILT = 40,
    parameter int ACC_W  = 42,
    parameter int OUT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_valid,
    output logic             pwr_ready,
    input  logic [31:0]      pwr_data,
    input  logic             pwr_last,
    output logic [9:0]       lut_addr,
    output logic             lut_wr_en,
    output logic [16:0]      lut_wr_data,
    input  logic [16:0]      lut_rd_data,
    output logic             fb_valid,
    output logic [5:0]       fb_idx,
    output logic [OUT_W-1:0] fb_data,
    output logic             frame_done
);

    localparam int         CNT_W    = $clog2(N_BINS) + 1;
    localparam logic [5:0] PTR_LAST = 6'(N_FILT + 2);

    function automatic logic [OUT_W-1:0] sat_energy(input logic [ACC_W-1:0] acc);
        if (|acc[ACC_W-1:OUT_W]) return '1;
        return acc[OUT_W-1:0];
    endfunction

    state_t               state;
    logic [CNT_W-1:0]     bin_cnt;
    // seg_ptr = number of edges below bin_cnt; a bin in segment k carries ptr k+1
    logic [5:0]           seg_ptr;
    logic [5:0]           cur_ptr;
    logic                 edge_hit;
    logic                 accept;
    logic                 flush_exit;

    logic                 vld_p0;
    logic [31:0]          pwr_p0;
    logic [5:0]           ptr_p0;
    logic                 vld_p1;
    logic [5:0]           ptr_p1;
    logic [CONTRIB_W-1:0] rise_p1;
    logic [CONTRIB_W-1:0] fall_p1;

    logic [ACC_W-1:0]     acc_rise, acc_fall, acc_rise_nx, acc_fall_nx;
    logic [ACC_W-1:0]     rise_c, fall_c;
    logic [5:0]           ptr_p2, ptr_p2_nx;
    logic                 emit;
    logic [5:0]           emit_idx;

    assign pwr_ready   = (state == S_RUN) && !rst;
    assign accept      = pwr_valid && pwr_ready;
    assign lut_addr    = 10'(bin_cnt);
    assign lut_wr_en   = 1'b0;
    assign lut_wr_data = '0;
    assign edge_hit    = (int'(seg_ptr) <= N_FILT + 1) &&
                         (edge_at(int'(seg_ptr)) == 11'(bin_cnt));
    assign cur_ptr     = seg_ptr + 6'(edge_hit);
    assign flush_exit  = (state == S_FLUSH) && (ptr_p2 == PTR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RUN;
            bin_cnt <= '0;
            seg_ptr <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (accept) begin
                        bin_cnt <= bin_cnt + 1'b1;
                        seg_ptr <= cur_ptr;
                        if (pwr_last) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!vld_p0 && !vld_p1) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_exit) begin
                        state   <= S_RUN;
                        bin_cnt <= '0;
                        seg_ptr <= '0;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // ---- stage p0: bin accepted, RAM address sampled ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pwr_p0 <= pwr_data;
            ptr_p0 <= cur_ptr;
        end
        ptr_p1 <= ptr_p0;
    end

    // ---- stage p1: weight returns, products registered ----
    fbank_mac u_mac (
        .clk    (clk),
        .en     (vld_p0),
        .pwr    (pwr_p0),
        .weight (lut_rd_data),
        .rise   (rise_p1),
        .fall   (fall_p1)
    );

    // ---- stage p2: accumulate, emit on segment change or flush step ----
    always_comb begin
        rise_c      = (ptr_p1 >= 6'd1 && ptr_p1 <= 6'(N_FILT))     ? ACC_W'(rise_p1) : '0;
        fall_c      = (ptr_p1 >= 6'd2 && ptr_p1 <= 6'(N_FILT + 1)) ? ACC_W'(fall_p1) : '0;
        acc_rise_nx = acc_rise;
        acc_fall_nx = acc_fall;
        ptr_p2_nx   = ptr_p2;
        emit        = 1'b0;
        emit_idx    = '0;
        if (vld_p1) begin
            if (ptr_p1 != ptr_p2) begin
                // entering segment k completes filter k-2, held in acc_fall
                ptr_p2_nx   = ptr_p1;
                emit        = (ptr_p1 >= 6'd3);
                emit_idx    = ptr_p1 - 6'd3;
                acc_fall_nx = acc_rise + fall_c;
                acc_rise_nx = rise_c;
            end else begin
                acc_rise_nx = acc_rise + rise_c;
                acc_fall_nx = acc_fall + fall_c;
            end
        end else if (state == S_FLUSH && ptr_p2 < PTR_LAST) begin
            // flush behaves like entering empty segments until the last filter
            ptr_p2_nx   = ptr_p2 + 6'd1;
            emit        = (ptr_p2_nx >= 6'd3);
            emit_idx    = ptr_p2_nx - 6'd3;
            acc_fall_nx = acc_rise;
            acc_rise_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_exit) begin
            acc_rise <= '0;
            acc_fall <= '0;
            ptr_p2   <= '0;
        end else begin
            acc_rise <= acc_rise_nx;
            acc_fall <= acc_fall_nx;
            ptr_p2   <= ptr_p2_nx;
        end
    end

    // ---- output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_valid   <= 1'b0;
            fb_idx     <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            fb_valid   <= emit;
            frame_done <= emit && (emit_idx == 6'(N_FILT - 1));
            if (emit) begin
                fb_idx  <= emit_idx;
                fb_data <= sat_energy(acc_fall);
            end
        end
    end

endmodule

// File: tb/tb_fbank_accum.sv
module tb_fbank_accum;
    import fbank_pkg::*;

    localparam int N_BINS = 512;
    localparam int N_FILT = 40;
    localparam int OUT_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwr_valid;
    logic             pwr_ready;
    logic [31:0]      pwr_data;
    logic             pwr_last;
    logic [9:0]       lut_addr;
    logic             lut_wr_en;
    logic [16:0]      lut_wr_data;
    logic [16:0]      lut_rd_data;
    logic             fb_valid;
    logic [5:0]       fb_idx;
    logic [OUT_W-1:0] fb_data;
    logic             frame_done;

    fbank_accum #(.N_BINS(N_BINS), .N_FILT(N_FILT), .ACC_W(42), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .pwr_valid(pwr_valid), .pwr_ready(pwr_ready),
        .pwr_data(pwr_data), .pwr_last(pwr_last), .lut_addr(lut_addr),
        .lut_wr_en(lut_wr_en), .lut_wr_data(lut_wr_data), .lut_rd_data(lut_rd_data),
        .fb_valid(fb_valid), .fb_idx(fb_idx), .fb_data(fb_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [31:0] pmem [N_BINS];
    logic [16:0] wmem [1024];

    // weight RAM: registered read, data valid the cycle after the address
    always @(posedge clk) lut_rd_data <= wmem[lut_addr];

    typedef struct {
        int          mode;      // 0 impulse at MEL_EDGE[3], 1 constant, 2 varied
        logic [31:0] pwr;
        logic [16:0] wgt;
        int          nb;
        bit          bub;
        bit          chk_lat;
        bit          chk_rdy;
        int          flush_from;
        int          s0_idx;
        longint      s0_val;
        int          s1_idx;
        longint      s1_val;
    } vec_t;

    vec_t vecs [6];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int bin_i, exp_idx, n_emit, order_err, addr_err;
    int done_seen, done_cyc, done_err, ready_cyc, ready_hi_err;
    bit last_acc, tick_acc;
    logic [31:0] got [64];
    int emit_cyc [64];
    int acc_cyc [N_BINS];
    longint expv [64];

    task automatic check(input string nm, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    endtask

    task automatic clear_rec();
        bin_i = 0; exp_idx = 0; n_emit = 0; order_err = 0; addr_err = 0;
        done_seen = 0; done_cyc = -1; done_err = 0; ready_cyc = -1; ready_hi_err = 0;
        last_acc = 0;
        for (int i = 0; i < 64; i++) begin got[i] = 32'hDEADBEEF; emit_cyc[i] = -1; end
        for (int i = 0; i < N_BINS; i++) acc_cyc[i] = -1;
    endtask

    // one clock: sample outputs at the falling edge, then advance past the rising edge
    task automatic tick();
        @(negedge clk);
        if (last_acc && done_seen == 0 && pwr_ready) ready_hi_err++;
        tick_acc = pwr_valid && pwr_ready;
        if (tick_acc) begin
            if (lut_addr != 10'(bin_i)) addr_err++;
            if (bin_i < N_BINS) acc_cyc[bin_i] = cyc;
            bin_i++;
            if (pwr_last) last_acc = 1;
        end
        if (fb_valid) begin
            if (int'(fb_idx) != exp_idx) order_err++;
            got[fb_idx] = fb_data;
            emit_cyc[fb_idx] = cyc;
            n_emit++;
            exp_idx++;
        end
        if (frame_done) begin
            done_seen++;
            done_cyc = cyc;
            if (!fb_valid || int'(fb_idx) != N_FILT - 1) done_err++;
        end
        if (done_seen > 0 && ready_cyc < 0 && pwr_ready) ready_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill_mem(input int mode, input logic [31:0] p, input logic [16:0] w);
        for (int b = 0; b < 1024; b++) begin
            if (mode == 2) wmem[b] = 17'((b * 1237) % 65537);
            else           wmem[b] = w;
        end
        for (int b = 0; b < N_BINS; b++) begin
            case (mode)
                0:       pmem[b] = (b == int'(MEL_EDGE[3])) ? p : 32'd0;
                1:       pmem[b] = p;
                default: pmem[b] = 32'(b) * 32'd104729 + 32'd7;
            endcase
        end
    endtask

    // direct per-filter sum over the triangle support
    task automatic golden(input int nb);
        longint unsigned s, pp, ww;
        for (int j = 0; j < N_FILT; j++) begin
            s = 0;
            for (int b = int'(MEL_EDGE[j]); b < int'(MEL_EDGE[j+2]) && b < nb; b++) begin
                pp = longint'(pmem[b]);
                ww = longint'(wmem[b]);
                if (b < int'(MEL_EDGE[j+1])) s += (pp * ww) >> 16;
                else                         s += (pp * (65536 - ww)) >> 16;
            end
            expv[j] = (s > 64'hFFFFFFFF) ? 64'hFFFFFFFF : longint'(s);
        end
    endtask

    task automatic drive_bins(input int nb, input bit bub, input int abort_at, output int sent);
        int b = 0;
        int guard = 0;
        while (b < nb && guard < 20000 && !(abort_at >= 0 && b == abort_at)) begin
            guard++;
            if (bub && $urandom_range(0, 1) == 0) begin
                pwr_valid = 0; pwr_last = 0;
                tick();
            end else begin
                pwr_valid = 1; pwr_data = pmem[b]; pwr_last = (b == nb - 1);
                tick();
                if (tick_acc) b++;
            end
        end
        pwr_valid = 0; pwr_last = 0;
        sent = b;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_seen == 0 && k < 800) begin tick(); k++; end
        repeat (6) tick();
    endtask

    task automatic check_frame(input string tag, input int nb);
        golden(nb);
        check({tag, " emit_count"}, n_emit, N_FILT);
        check({tag, " idx_order_errs"}, order_err, 0);
        check({tag, " lut_addr_errs"}, addr_err, 0);
        check({tag, " frame_done_count"}, done_seen, 1);
        check({tag, " frame_done_idx_errs"}, done_err, 0);
        for (int j = 0; j < N_FILT; j++)
            check($sformatf("%s filt%0d", tag, j), longint'(got[j]), expv[j]);
    endtask

    initial begin
        int sent;
        vecs[0] = '{0, 32'h0001_0000, 17'h04000, 512, 1'b0, 1'b0, 1'b0, 0, 3, 64'h4000, 2, 64'hC000};
        vecs[1] = '{1, 32'h0001_0000, 17'h08000, 512, 1'b0, 1'b1, 1'b0, 0, 0, 64'h40000, 39, 64'h110000};
        vecs[2] = '{1, 32'hFFFF_FFFF, 17'h10000, 512, 1'b0, 1'b0, 1'b0, 0, 5, 64'hFFFFFFFF, 39, 64'hFFFFFFFF};
        vecs[3] = '{1, 32'h0001_0000, 17'h08000, 101, 1'b0, 1'b0, 1'b1, 16, 16, 64'h80000, 20, 64'h0};
        vecs[4] = '{1, 32'h0001_0000, 17'h08000, 512, 1'b1, 1'b0, 1'b0, 0, 0, 64'h40000, 39, 64'h110000};
        vecs[5] = '{2, 32'h0, 17'h0, 512, 1'b1, 1'b0, 1'b0, 0, -1, 64'h0, -1, 64'h0};

        rst = 1; pwr_valid = 0; pwr_data = 0; pwr_last = 0;
        fill_mem(1, 32'd0, 17'd0);
        clear_rec();
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst pwr_ready", pwr_ready, 0);
        check("rst fb_valid", fb_valid, 0);
        check("rst fb_idx", fb_idx, 0);
        check("rst fb_data", fb_data, 0);
        check("rst frame_done", frame_done, 0);
        check("rst lut_addr", lut_addr, 0);
        check("lut_wr_en", lut_wr_en, 0);
        check("lut_wr_data", lut_wr_data, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post-rst pwr_ready", pwr_ready, 1);
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            fill_mem(vecs[v].mode, vecs[v].pwr, vecs[v].wgt);
            clear_rec();
            drive_bins(vecs[v].nb, vecs[v].bub, -1, sent);
            check({tag, " bins_sent"}, sent, vecs[v].nb);
            wait_done();
            check_frame(tag, vecs[v].nb);
            if (vecs[v].s0_idx >= 0)
                check($sformatf("%s spot filt%0d", tag, vecs[v].s0_idx), longint'(got[vecs[v].s0_idx]), vecs[v].s0_val);
            if (vecs[v].s1_idx >= 0)
                check($sformatf("%s spot filt%0d", tag, vecs[v].s1_idx), longint'(got[vecs[v].s1_idx]), vecs[v].s1_val);
            if (vecs[v].chk_lat)
                for (int j = 0; j < N_FILT; j++)
                    check($sformatf("%s latency filt%0d", tag, j),
                          emit_cyc[j] - acc_cyc[MEL_EDGE[j+2]], 3);
            if (vecs[v].chk_rdy) begin
                check({tag, " ready_after_done"}, ready_cyc, done_cyc + 1);
                check({tag, " ready_high_while_flushing"}, ready_hi_err, 0);
                for (int j = vecs[v].flush_from; j < N_FILT - 1; j++)
                    check($sformatf("%s flush_spacing filt%0d", tag, j + 1),
                          emit_cyc[j + 1] - emit_cyc[j], 1);
            end
        end

        // reset mid-frame at bin 200, then a clean full frame
        fill_mem(2, 32'd0, 17'd0);
        clear_rec();
        drive_bins(512, 1'b0, 200, sent);
        check("abort bins_sent", sent, 200);
        rst = 1;
        tick();
        clear_rec();
        check("abort rst pwr_ready", pwr_ready, 0);
        tick();
        rst = 0;
        repeat (12) tick();
        check("abort fb_valid_count", n_emit, 0);
        check("abort frame_done_count", done_seen, 0);
        clear_rec();
        drive_bins(512, 1'b0, -1, sent);
        check("after_abort bins_sent", sent, 512);
        wait_done();
        check_frame("after_abort", 512);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
